lcd8080_rx_ctrl: RTL

Parametrised i8080-to-RGB front end. It oversamples the i8080 write strobe in the system clock domain, decodes command writes into a control register file and assembles data writes into full pixels pushed to the line FIFO. It also contains a built-in colour-bar test generator, driven by HSYNC/VSYNC, that feeds the same FIFO port. It sits between the i8080 pads and the pixel FIFO / RGB timing generator.

---
 rtl/lcd8080_rx_ctrl_if.sv | 30 +++
 rtl/lcd8080_rx_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lcd8080_rx_ctrl_if.sv
// Pad-side and FIFO-side signal bundle for lcd8080_rx_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface lcd8080_rx_ctrl_if #(
  parameter int unsigned BUS_W = 8,
  parameter int unsigned PIX_W = 16
) ();
  logic             HSYNC;
  logic             VSYNC;
  logic             J80_WR_n;
  logic             J80_RS;
  logic [BUS_W-1:0] J80_Data;
  logic             J80_Re;
  logic [PIX_W-1:0] FIFO_WData;
  logic             FIFO_We;
  logic             FIFO_Full;
  logic             LCD_BL;
  logic             FrameCtrl;
  logic             Ovf;
  logic [7:0]       OvfCnt;

  modport slave (
    input  HSYNC, VSYNC, J80_WR_n, J80_RS, J80_Data, FIFO_Full,
    output J80_Re, FIFO_WData, FIFO_We, LCD_BL, FrameCtrl, Ovf, OvfCnt
  );

  modport master (
    output HSYNC, VSYNC, J80_WR_n, J80_RS, J80_Data, FIFO_Full,
    input  J80_Re, FIFO_WData, FIFO_We, LCD_BL, FrameCtrl, Ovf, OvfCnt
  );
endinterface

// File: rtl/lcd8080_rx_ctrl.sv
// i8080 write receiver: command register file, pixel assembly and colour-bar test source.
// Optional macro LCD_OVF_CNT_EN adds the 8-bit saturating dropped-pixel counter on OvfCnt.
module lcd8080_rx_ctrl #(
  parameter int unsigned BUS_W     = 8,
  parameter int unsigned PIX_W     = 16,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned BAR_COUNT = 4
) (
  input logic              CLK,
  input logic              nRST,
  lcd8080_rx_ctrl_if.slave bus
);
  localparam int unsigned Beats = PIX_W / BUS_W;
  localparam int unsigned BarW  = H_ACTIVE / BAR_COUNT;
  localparam int unsigned XW    = $clog2(H_ACTIVE + 1);
  localparam int unsigned SegW  = (BarW > 1) ? $clog2(BarW) : 1;

  localparam logic [2:0] AddrCtrl = 3'b001;
  localparam logic [2:0] AddrPix  = 3'b010;
  localparam logic [2:0] AddrBl   = 3'b011;
  localparam logic [2:0] AddrTest = 3'b100;
  localparam logic [2:0] AddrStat = 3'b101;

  typedef enum logic [1:0] {StBeat0, StBeat1, StBeat2, StBeat3} beat_e;

  // Synchronisers; WR_n idles high so reset must not fake a rising edge.
  logic             wr_meta_q, wr_sync_q, wr_prev_q;
  logic             rs_meta_q, rs_sync_q;
  logic [BUS_W-1:0] data_meta_q, data_sync_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_meta_q   <= 1'b1;
      wr_sync_q   <= 1'b1;
      wr_prev_q   <= 1'b1;
      rs_meta_q   <= 1'b0;
      rs_sync_q   <= 1'b0;
      data_meta_q <= '0;
      data_sync_q <= '0;
    end else begin
      wr_meta_q   <= bus.J80_WR_n;
      wr_sync_q   <= wr_meta_q;
      wr_prev_q   <= wr_sync_q;
      rs_meta_q   <= bus.J80_RS;
      rs_sync_q   <= rs_meta_q;
      data_meta_q <= bus.J80_Data;
      data_sync_q <= data_meta_q;
    end
  end

  logic       wr_evt, cmd_evt, dat_evt;
  logic [2:0] cmd_addr;
  logic [4:0] cmd_pay;

  assign wr_evt   = wr_sync_q & ~wr_prev_q;
  assign cmd_evt  = wr_evt & rs_sync_q;
  assign dat_evt  = wr_evt & ~rs_sync_q;
  assign cmd_addr = data_sync_q[7:5];
  assign cmd_pay  = data_sync_q[4:0];

  logic [4:0]       ctrl_q, pix_q, bl_q, test_q;
  beat_e            beat_q;
  logic [PIX_W-1:0] shift_q;
  logic [PIX_W-1:0] fifo_wdata_q;
  logic             fifo_we_q;
  logic             ovf_q;
  logic [XW-1:0]    x_q;
  logic [SegW-1:0]  seg_q;
  logic [2:0]       bar_q;

  logic             test_en, beat_last, host_push_evt, drop, stat_clr, mode_switch;
  logic [PIX_W-1:0] asm_word;

  assign test_en       = ctrl_q[2];
  assign beat_last     = (beat_q == beat_e'(2'(Beats - 1)));
  assign asm_word      = (shift_q << BUS_W) | PIX_W'(data_sync_q);
  assign host_push_evt = dat_evt & ~test_en & beat_last;
  assign drop          = host_push_evt & bus.FIFO_Full;
  assign stat_clr      = cmd_evt & (cmd_addr == AddrStat) & cmd_pay[0];
  assign mode_switch   = cmd_evt & (cmd_addr == AddrCtrl) & (cmd_pay[2] != ctrl_q[2]);

  // Colour bars are 16-bit RGB565; wider/narrower pixels pad or trim at the LSB end.
  function automatic logic [PIX_W-1:0] fit_colour(input logic [15:0] c);
    logic [PIX_W+15:0] ext;
    ext = {c, {PIX_W{1'b0}}};
    return ext[PIX_W+15 -: PIX_W];
  endfunction

  logic [15:0]      bar_colour;
  logic [PIX_W-1:0] test_pix;

  always_comb begin
    bar_colour = 16'h0000;
    case (bar_q)
      3'd0:    bar_colour = 16'h001F;
      3'd1:    bar_colour = 16'h07E0;
      3'd2:    bar_colour = 16'hF800;
      3'd3:    bar_colour = 16'hFFFF;
      3'd4:    bar_colour = 16'h0000;
      3'd5:    bar_colour = 16'hFFE0;
      3'd6:    bar_colour = 16'h07FF;
      default: bar_colour = 16'hF81F;
    endcase
  end

  assign test_pix = test_q[4] ? PIX_W'({16{test_q[3:0]}}) : fit_colour(bar_colour);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_q       <= 5'b01000;
      pix_q        <= 5'b00000;
      bl_q         <= 5'b00001;
      test_q       <= 5'b00000;
      beat_q       <= StBeat0;
      shift_q      <= '0;
      fifo_wdata_q <= '0;
      fifo_we_q    <= 1'b0;
      ovf_q        <= 1'b0;
      x_q          <= '0;
      seg_q        <= '0;
      bar_q        <= '0;
    end else begin
      fifo_we_q <= 1'b0;

      if (cmd_evt) begin
        beat_q <= StBeat0;
        case (cmd_addr)
          AddrCtrl: ctrl_q <= cmd_pay;
          AddrPix:  pix_q  <= cmd_pay;
          AddrBl:   bl_q   <= cmd_pay;
          AddrTest: test_q <= cmd_pay;
          AddrStat: if (cmd_pay[0]) ovf_q <= 1'b0;
          default:  ;
        endcase
      end else if (dat_evt && !test_en) begin
        shift_q <= asm_word;
        if (beat_last) begin
          beat_q <= StBeat0;
          if (bus.FIFO_Full) begin
            ovf_q <= 1'b1;
          end else begin
            fifo_we_q    <= 1'b1;
            fifo_wdata_q <= asm_word;
          end
        end else begin
          beat_q <= beat_e'(beat_q + 2'd1);
        end
      end

      // Test source; never coincides with a host push since host data is ignored here.
      if (mode_switch || (test_en && (bus.HSYNC || bus.VSYNC))) begin
        x_q   <= '0;
        seg_q <= '0;
        bar_q <= '0;
      end else if (test_en && (x_q < XW'(H_ACTIVE)) && !bus.FIFO_Full) begin
        fifo_we_q    <= 1'b1;
        fifo_wdata_q <= test_pix;
        x_q          <= x_q + 1'b1;
        if (seg_q == SegW'(BarW - 1)) begin
          seg_q <= '0;
          bar_q <= bar_q + 3'd1;
        end else begin
          seg_q <= seg_q + 1'b1;
        end
      end
    end
  end

`ifdef LCD_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf_cnt_q <= 8'd0;
    end else if (stat_clr) begin
      ovf_cnt_q <= 8'd0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign bus.OvfCnt = ovf_cnt_q;
`else
  logic unused_cnt_evt;
  assign unused_cnt_evt = stat_clr ^ drop;
  assign bus.OvfCnt     = 8'd0;
`endif

  assign bus.J80_Re     = ctrl_q[3] ? (bus.HSYNC | bus.VSYNC) : bus.HSYNC;
  assign bus.FrameCtrl  = ctrl_q[3] ? 1'b1 : pix_q[0];
  assign bus.LCD_BL     = bl_q[0];
  assign bus.FIFO_We    = fifo_we_q;
  assign bus.FIFO_WData = fifo_wdata_q;
  assign bus.Ovf        = ovf_q;

  // Display-on and reserved bits are host-visible storage only.
  logic unused_bits;
  assign unused_bits = ^{ctrl_q[4], ctrl_q[1:0], pix_q[4:1], bl_q[4:1]};
endmodule
